// File: rtl/operand_entry_if.sv
// Button/operand bundle between the board front end and operand_entry.
// The master drives the raw buttons; the slave (operand_entry) returns the operands and status.
interface operand_entry_if #(
    parameter int WIDTH = 3
);
    logic [3:0]       buttons;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             valid;
    logic [1:0]       phase;
    logic [3:0]       press;

    modport master (
        output buttons,
        input  in1, in2, valid, phase, press
    );

    modport slave (
        input  buttons,
        output in1, in2, valid, phase, press
    );
endinterface

// File: rtl/operand_entry.sv
// Operand entry front end: synchronises, debounces and edge-detects four buttons,
// then drives an entry FSM that builds operand A, then operand B, then reports valid.
module operand_entry #(
    parameter int DB_CYCLES = 500000,
    parameter int WIDTH     = 3
) (
    input  logic           clk,
    input  logic           reset,
    operand_entry_if.slave bus
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    typedef enum logic [1:0] {
        ENTER_A = 2'b00,
        ENTER_B = 2'b01,
        DONE    = 2'b10
    } state_e;

    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    stable_q, stable_d, stable_prev_q;
    logic [3:0]    press_q;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];

    state_e           state_q;
    logic [WIDTH-1:0] in1_q, in2_q;
    logic             valid_q;

    // Stable level flips on the cycle the difference has persisted DB_CYCLES cycles.
    for (genvar gi = 0; gi < 4; gi++) begin : g_db
        logic diff;
        logic last;
        assign diff          = sync2_q[gi] != stable_q[gi];
        assign last          = cnt_q[gi] == CW'(DB_CYCLES - 1);
        assign cnt_d[gi]     = (diff && !last) ? cnt_q[gi] + 1'b1 : '0;
        assign stable_d[gi]  = (diff && last) ? sync2_q[gi] : stable_q[gi];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            press_q       <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q       <= bus.buttons;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            press_q       <= stable_q & ~stable_prev_q;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Only the highest-priority pulse acts: restart > advance > clear > increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ENTER_A;
            in1_q   <= '0;
            in2_q   <= '0;
            valid_q <= 1'b0;
        end else if (press_q[3]) begin
            state_q <= ENTER_A;
            in1_q   <= '0;
            in2_q   <= '0;
            valid_q <= 1'b0;
        end else if (press_q[2]) begin
            case (state_q)
                ENTER_A: state_q <= ENTER_B;
                ENTER_B: begin
                    state_q <= DONE;
                    valid_q <= 1'b1;
                end
                DONE: begin
                    state_q <= ENTER_A;
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= ENTER_A;
                    valid_q <= 1'b0;
                end
            endcase
        end else if (press_q[1]) begin
            if (state_q == ENTER_A) in1_q <= '0;
            else if (state_q == ENTER_B) in2_q <= '0;
        end else if (press_q[0]) begin
            if (state_q == ENTER_A) in1_q <= in1_q + 1'b1;
            else if (state_q == ENTER_B) in2_q <= in2_q + 1'b1;
        end
    end

    assign bus.in1   = in1_q;
    assign bus.in2   = in2_q;
    assign bus.valid = valid_q;
    assign bus.phase = state_q;
    assign bus.press = press_q;
endmodule

// File: tb/tb_operand_entry.sv
// Directed, table-driven bench for operand_entry with a short debounce window.
module tb_operand_entry;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cmp_cnt = 0;
    int   err_cnt = 0;

    operand_entry_if #(.WIDTH(3)) bus ();

    operand_entry #(.DB_CYCLES(DB), .WIDTH(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] btn;
        int         hold;
        logic [3:0] e_press;
        logic [2:0] e_in1;
        logic [2:0] e_in2;
        logic [1:0] e_phase;
        logic       e_valid;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] b, int h, logic [3:0] p,
                                logic [2:0] a, logic [2:0] c, logic [1:0] ph, logic v);
        vec_t r;
        r.btn = b; r.hold = h; r.e_press = p;
        r.e_in1 = a; r.e_in2 = c; r.e_phase = ph; r.e_valid = v;
        return r;
    endfunction

    task automatic check(string name, int act, int exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] p_in1, p_in2;
        logic [1:0] p_phase;
        logic       p_valid;
        int         pulses;
        int         lat;

        // bounce, then nine increments (wrap 7 -> 0)
        vecs.push_back(mk(4'b0001, 3, 4'b0000, 0, 0, 2'b00, 0));
        for (int k = 1; k <= 9; k++)
            vecs.push_back(mk(4'b0001, 10, 4'b0001, 3'(k % 8), 0, 2'b00, 0));
        vecs.push_back(mk(4'b0010, 10, 4'b0010, 0, 0, 2'b00, 0));
        for (int k = 1; k <= 5; k++)
            vecs.push_back(mk(4'b0001, 10, 4'b0001, 3'(k), 0, 2'b00, 0));
        vecs.push_back(mk(4'b0100, 10, 4'b0100, 5, 0, 2'b01, 0));
        for (int k = 1; k <= 3; k++)
            vecs.push_back(mk(4'b0001, 10, 4'b0001, 5, 3'(k), 2'b01, 0));
        vecs.push_back(mk(4'b0100, 10, 4'b0100, 5, 3, 2'b10, 1));
        vecs.push_back(mk(4'b0001, 10, 4'b0001, 5, 3, 2'b10, 1));
        vecs.push_back(mk(4'b0010, 10, 4'b0010, 5, 3, 2'b10, 1));
        vecs.push_back(mk(4'b0100, 10, 4'b0100, 5, 3, 2'b00, 0));
        vecs.push_back(mk(4'b0100, 10, 4'b0100, 5, 3, 2'b01, 0));
        vecs.push_back(mk(4'b0100, 10, 4'b0100, 5, 3, 2'b10, 1));
        vecs.push_back(mk(4'b1001, 10, 4'b1001, 0, 0, 2'b00, 0));
        vecs.push_back(mk(4'b0001, 10, 4'b0001, 1, 0, 2'b00, 0));
        vecs.push_back(mk(4'b0100, 10, 4'b0100, 1, 0, 2'b01, 0));
        vecs.push_back(mk(4'b0001, 10, 4'b0001, 1, 1, 2'b01, 0));

        bus.buttons = 4'b0000;
        reset = 1'b0;
        #1;
        check("reset_in1", int'(bus.in1), 0);
        check("reset_in2", int'(bus.in2), 0);
        check("reset_valid", int'(bus.valid), 0);
        check("reset_phase", int'(bus.phase), 0);
        check("reset_press", int'(bus.press), 0);
        repeat (3) step();
        reset = 1'b1;
        for (int c = 0; c < 50; c++) begin
            step();
            check("idle_outputs", int'({bus.in1, bus.in2, bus.valid, bus.phase, bus.press}), 0);
        end
        $display("idle: 50 cycles after reset release, outputs checked");

        p_in1 = 0; p_in2 = 0; p_phase = 0; p_valid = 0;
        for (int v = 0; v < vecs.size(); v++) begin
            bus.buttons = vecs[v].btn;
            pulses = 0;
            for (int c = 1; c <= 20; c++) begin
                step();
                if (c == vecs[v].hold) bus.buttons = 4'b0000;
                if (bus.press != 4'b0000) pulses++;
                if (c == 7) begin
                    check("press_lat7", int'(bus.press), int'(vecs[v].e_press));
                    check("hold_lat7", int'({bus.in1, bus.in2, bus.phase, bus.valid}),
                          int'({p_in1, p_in2, p_phase, p_valid}));
                end
                if (c == 8) begin
                    check("in1", int'(bus.in1), int'(vecs[v].e_in1));
                    check("in2", int'(bus.in2), int'(vecs[v].e_in2));
                    check("phase", int'(bus.phase), int'(vecs[v].e_phase));
                    check("valid", int'(bus.valid), int'(vecs[v].e_valid));
                end
            end
            check("pulse_count", pulses, (vecs[v].e_press != 4'b0000) ? 1 : 0);
            $display("vec %0d: btn=%b in1=%0d in2=%0d phase=%b valid=%0d pulses=%0d",
                     v, vecs[v].btn, bus.in1, bus.in2, bus.phase, bus.valid, pulses);
            p_in1 = vecs[v].e_in1; p_in2 = vecs[v].e_in2;
            p_phase = vecs[v].e_phase; p_valid = vecs[v].e_valid;
        end

        // advance held across a reset taken mid-debounce in ENTER_B
        bus.buttons = 4'b0100;
        repeat (3) step();
        reset = 1'b0;
        #1;
        check("rst_mid_phase", int'(bus.phase), 0);
        check("rst_mid_ops", int'({bus.in1, bus.in2}), 0);
        check("rst_mid_valid", int'(bus.valid), 0);
        check("rst_mid_press", int'(bus.press), 0);
        repeat (3) step();
        reset = 1'b1;
        lat = 0;
        pulses = 0;
        while (bus.press[2] !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        check("held_press_latency", lat, 7);
        if (bus.press[2] === 1'b1) pulses++;
        step();
        check("held_phase", int'(bus.phase), 1);
        check("held_ops", int'({bus.in1, bus.in2}), 0);
        for (int c = 0; c < 12; c++) begin
            if (bus.press != 4'b0000) pulses++;
            step();
        end
        check("held_pulse_count", pulses, 1);
        check("held_phase_final", int'(bus.phase), 1);
        $display("reset-hold: latency=%0d pulses=%0d phase=%b", lat, pulses, bus.phase);
        bus.buttons = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
